carry_propagation_buffer: RTL and testbench

- Downstream of the encoder's final pipeline register; consumes one renormalised byte plus carry flag per accepted transfer.
- Resolves deferred carries: holds the most recent non-0xFF byte and counts the trailing run of 0xFF bytes until a carry resolves them.
- Emits final bitstream bytes over a ready/valid interface and performs an end-of-frame flush.

---
 rtl/carry_propagation_buffer_pkg.sv | 19 +
 rtl/carry_propagation_buffer_run_counter.sv | 45 ++++
 rtl/carry_propagation_buffer.sv | 182 ++++++++++++++++++
 tb/tb_carry_propagation_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_propagation_buffer_pkg.sv
// Shared encodings and helpers for the carry propagation buffer.
package carry_propagation_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        RUN   = 2'd2,
        FDONE = 2'd3
    } cpb_state_e;

    localparam logic [7:0] BYTE_FF      = 8'hFF;
    localparam int         IN_CARRY_BIT = 8;

    function automatic logic [7:0] add_carry(input logic [7:0] b,
                                             input logic       c);
        return b + {7'd0, c};
    endfunction

endpackage

// File: rtl/carry_propagation_buffer_run_counter.sv
// Saturating up/down counter tracking the pending run of 0xFF bytes.
module carry_run_counter
    import carry_propagation_buffer_pkg::*;
#(
    parameter int RUN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [RUN_W-1:0] count,
    output logic             is_zero,
    output logic             is_one,
    output logic             is_max
);

    logic [RUN_W-1:0] count_q;
    logic [RUN_W-1:0] count_d;

    assign count   = count_q;
    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == RUN_W'(1));
    assign is_max  = &count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !is_max) begin
            count_d = count_q + RUN_W'(1);
        end else if (dec && !is_zero) begin
            count_d = count_q - RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/carry_propagation_buffer.sv
// Resolves deferred carries over a held byte plus a trailing 0xFF run
// and streams the final bitstream bytes with an end-of-frame flush.
module carry_propagation_buffer
    import carry_propagation_buffer_pkg::*;
#(
    parameter int RUN_W = 16
) (
    input  logic       clk,
    input  logic       reset_ctrl,
    input  logic       in_valid,
    input  logic [8:0] in_data,
    output logic       in_ready,
    input  logic       flush_req,
    output logic       flush_done,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       err_overflow
);

    cpb_state_e state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] stage_q, stage_d;
    logic       carry_l_q, carry_l_d;
    logic       flush_q, flush_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       flush_done_q, flush_done_d;
    logic       err_q, err_d;

    logic             run_clr, run_inc, run_dec;
    logic             run_zero, run_one, run_max;
    logic [RUN_W-1:0] run_count;
    logic             commit;

    logic [7:0] in_byte;
    logic       in_carry;
    logic       xfer;

    assign in_byte  = in_data[7:0];
    assign in_carry = in_data[IN_CARRY_BIT];
    assign in_ready = (state_q == IDLE);
    assign xfer     = in_valid && in_ready;

    assign out_valid    = out_valid_q;
    assign out_byte     = out_byte_q;
    assign flush_done   = flush_done_q;
    assign err_overflow = err_q;

    carry_run_counter #(
        .RUN_W(RUN_W)
    ) u_run (
        .clk    (clk),
        .rst_n  (reset_ctrl),
        .clr    (run_clr),
        .inc    (run_inc),
        .dec    (run_dec),
        .count  (run_count),
        .is_zero(run_zero),
        .is_one (run_one),
        .is_max (run_max)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        stage_d      = stage_q;
        carry_l_d    = carry_l_q;
        flush_d      = flush_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        flush_done_d = 1'b0;
        err_d        = err_q;
        run_clr      = 1'b0;
        run_inc      = 1'b0;
        run_dec      = 1'b0;
        commit       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!hold_valid_q) begin
                        hold_d       = in_byte;
                        hold_valid_d = 1'b1;
                    end else if (!in_carry && in_byte == BYTE_FF) begin
                        if (run_max) begin
                            err_d = 1'b1;
                        end else begin
                            run_inc = 1'b1;
                        end
                    end else begin
                        carry_l_d   = in_carry;
                        stage_d     = in_byte;
                        flush_d     = 1'b0;
                        state_d     = HEAD;
                        out_valid_d = 1'b1;
                        out_byte_d  = add_carry(hold_q, in_carry);
                    end
                end else if (flush_req) begin
                    if (hold_valid_q) begin
                        carry_l_d   = 1'b0;
                        stage_d     = 8'h00;
                        flush_d     = 1'b1;
                        state_d     = HEAD;
                        out_valid_d = 1'b1;
                        out_byte_d  = hold_q;
                    end else begin
                        state_d      = FDONE;
                        flush_done_d = 1'b1;
                    end
                end
            end
            HEAD: begin
                if (out_ready) begin
                    if (!run_zero) begin
                        state_d    = RUN;
                        out_byte_d = carry_l_q ? 8'h00 : BYTE_FF;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    run_dec = 1'b1;
                    commit  = run_one;
                end
            end
            FDONE: begin
                state_d = IDLE;
            end
        endcase

        // Commit retires the emission; flush frames end in FDONE.
        if (commit) begin
            out_valid_d = 1'b0;
            run_clr     = 1'b1;
            if (flush_q) begin
                hold_valid_d = 1'b0;
                flush_d      = 1'b0;
                state_d      = FDONE;
                flush_done_d = 1'b1;
            end else begin
                hold_d       = stage_q;
                hold_valid_d = 1'b1;
                state_d      = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_ctrl) begin
        if (!reset_ctrl) begin
            state_q      <= IDLE;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            stage_q      <= 8'h00;
            carry_l_q    <= 1'b0;
            flush_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            stage_q      <= stage_d;
            carry_l_q    <= carry_l_d;
            flush_q      <= flush_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^run_count;

endmodule

// File: tb/tb_carry_propagation_buffer.sv
// Directed bench for carry_propagation_buffer (RUN_W=2 to reach saturation).
module tb_carry_propagation_buffer;

    logic       clk = 1'b0;
    logic       reset_ctrl;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       flush_req;
    logic       flush_done;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       err_overflow;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    carry_propagation_buffer #(
        .RUN_W(2)
    ) dut (
        .clk         (clk),
        .reset_ctrl  (reset_ctrl),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .out_valid   (out_valid),
        .out_byte    (out_byte),
        .out_ready   (out_ready),
        .err_overflow(err_overflow)
    );

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_byte);
        if (flush_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_stream(input string tag, input int exp_done);
        logic [31:0] o;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD;
            chk($sformatf("%s_byte%0d", tag, i), o, {24'd0, exp_q[i]});
        end
        chk({tag, "_done"}, done_cnt, exp_done);
        got.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic c, input logic [7:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = {c, b};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_idle_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input string tag);
        bit ok = 0;
        flush_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (flush_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_flush_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        chk({tag, "_done_pulse_end"}, flush_done, 1'b0);
    endtask

    initial begin
        reset_ctrl = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush_req  = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_err", err_overflow, 1'b0);
        @(negedge clk);
        reset_ctrl = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Plain bytes
        send(1'b0, 8'h12);
        chk("plain_hold_no_out", out_valid, 1'b0);
        send(1'b0, 8'h34);
        chk("plain_head_valid", out_valid, 1'b1);
        chk("plain_head_byte", out_byte, 8'h12);
        chk("plain_in_ready_low", in_ready, 1'b0);
        send(1'b0, 8'h56);
        do_flush("plain");
        exp_q = '{8'h12, 8'h34, 8'h56};
        check_stream("plain", 1);

        // Run without carry, run reaches max (3) without overflow
        send(1'b0, 8'h40);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        chk("nocarry_no_out", out_valid, 1'b0);
        send(1'b0, 8'h10);
        wait_idle("nocarry");
        chk("nocarry_err", err_overflow, 1'b0);
        exp_q = '{8'h40, 8'hFF, 8'hFF, 8'hFF};
        check_stream("nocarry", 0);

        // Run with carry; emits held 0x10 first
        send(1'b0, 8'h7E);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        send(1'b1, 8'h20);
        wait_idle("carry");
        exp_q = '{8'h10, 8'h7F, 8'h00, 8'h00};
        check_stream("carry", 0);

        // Backpressure in HEAD and RUN
        send(1'b0, 8'h7E);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        out_ready = 1'b0;
        send(1'b1, 8'h20);
        @(posedge clk);
        #1;
        chk("bp_head_valid", out_valid, 1'b1);
        chk("bp_head_byte", out_byte, 8'h7F);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_run_valid%0d", i), out_valid, 1'b1);
            chk($sformatf("bp_run_byte%0d", i), out_byte, 8'h00);
            chk($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        wait_idle("bp");
        do_flush("bp");
        exp_q = '{8'h20, 8'h7F, 8'h00, 8'h00, 8'h20};
        check_stream("bp", 1);

        // Overflow with RUN_W=2
        send(1'b0, 8'h01);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        chk("ovf_err_before", err_overflow, 1'b0);
        send(1'b0, 8'hFF);
        chk("ovf_err_after", err_overflow, 1'b1);
        chk("ovf_in_ready", in_ready, 1'b1);
        chk("ovf_no_out", out_valid, 1'b0);
        do_flush("ovf");
        chk("ovf_err_sticky", err_overflow, 1'b1);
        exp_q = '{8'h01, 8'hFF, 8'hFF, 8'hFF};
        check_stream("ovf", 1);

        // Reset during RUN
        send(1'b0, 8'h05);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        out_ready = 1'b0;
        send(1'b0, 8'h06);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rstrun_valid", out_valid, 1'b1);
        chk("rstrun_byte", out_byte, 8'hFF);
        reset_ctrl = 1'b0;
        #2;
        chk("rstrun_async_valid", out_valid, 1'b0);
        chk("rstrun_async_byte", out_byte, 8'h00);
        chk("rstrun_err_clr", err_overflow, 1'b0);
        @(negedge clk);
        reset_ctrl = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("rstrun_in_ready", in_ready, 1'b1);
        chk("rstrun_valid_after", out_valid, 1'b0);
        exp_q = '{8'h05};
        check_stream("rstrun", 0);

        // Flush with empty hold
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        chk("eflush_done", flush_done, 1'b1);
        chk("eflush_no_out", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("eflush_done_end", flush_done, 1'b0);
        chk("eflush_in_ready", in_ready, 1'b1);
        exp_q.delete();
        check_stream("eflush", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
